// File: rtl/coll_button_conditioner.sv
// coll_button_conditioner
// Front end for score_display. Synchronises and debounces the raw good/bad
// collision buttons, then emits exactly one single-cycle pulse per accepted press.
// Ports:
//   clk            system clock, all flops on posedge
//   rst            asynchronous active-low reset
//   goodCollRaw    raw good-collision button (asynchronous, bouncy)
//   badCollRaw     raw bad-collision button (asynchronous, bouncy)
//   goodCollButton 1-cycle pulse per accepted good press
//   badCollButton  1-cycle pulse per accepted bad press
//   goodHeld       high while the good channel is debounced-pressed (HELD/REL_WAIT)
//   badHeld        high while the bad channel is debounced-pressed (HELD/REL_WAIT)
// Build option: define COLL_AUTOREPEAT_EN to raise a repeat event every
// REPEAT_CYCLES cycles while a channel stays in HELD.
`timescale 1ns/1ps

module coll_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned REPEAT_CYCLES   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic goodCollRaw,
    input  logic badCollRaw,
    output logic goodCollButton,
    output logic badCollButton,
    output logic goodHeld,
    output logic badHeld
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                         : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned NCH     = 2;
    localparam int unsigned CH_GOOD = 0;
    localparam int unsigned CH_BAD  = 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_e;

    logic [NCH-1:0]   raw_c;
    logic [NCH-1:0]   meta_q, meta_d;
    logic [NCH-1:0]   sync_q, sync_d;
    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   press_ev_c;
    logic [NCH-1:0]   rep_ev_c;
    logic [NCH-1:0]   ev_c;
    logic [NCH-1:0]   held_q, held_d;
    logic             good_pulse_q, good_pulse_d;
    logic             bad_pulse_q, bad_pulse_d;
    logic             pend_q, pend_d;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign raw_c  = {badCollRaw, goodCollRaw};
    assign meta_d = raw_c;
    assign sync_d = meta_q;

    // Two-flop synchroniser per channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // Debounce FSM next state. cnt holds the stable cycles already seen, so the
    // current stable cycle completes the window when cnt equals DEBOUNCE_CYCLES-1.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            press_ev_c[i] = 1'b0;
            unique case (state_q[i])
                IDLE: begin
                    if (sync_q[i]) begin
                        if (cnt_q[i] == DEB_LAST) begin
                            state_d[i]    = HELD;
                            cnt_d[i]      = '0;
                            press_ev_c[i] = 1'b1;
                        end else begin
                            state_d[i] = PRESS_WAIT;
                            cnt_d[i]   = cnt_inc(cnt_q[i]);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i]    = HELD;
                        cnt_d[i]      = '0;
                        press_ev_c[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_inc(cnt_q[i]);
                    end
                end
                HELD: begin
                    if (!sync_q[i]) begin
                        if (cnt_q[i] == DEB_LAST) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = REL_WAIT;
                            cnt_d[i]   = cnt_inc(cnt_q[i]);
                        end
                    end
                end
                REL_WAIT: begin
                    if (sync_q[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] == HELD) || (state_d[i] == REL_WAIT);
        end
    end

    // Debounce FSM state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef COLL_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_q [NCH];
    logic [CNT_W-1:0] rep_d [NCH];

    // Repeat counter runs only while staying in HELD; any (re)entry starts at 0
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            rep_ev_c[i] = (state_q[i] == HELD) && (rep_q[i] == CNT_W'(REPEAT_CYCLES - 1));
            rep_d[i]    = '0;
            if ((state_q[i] == HELD) && (state_d[i] == HELD) && !rep_ev_c[i]) begin
                rep_d[i] = cnt_inc(rep_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                rep_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                rep_q[i] <= rep_d[i];
            end
        end
    end
`else
    assign rep_ev_c = '0;
`endif

    assign ev_c = press_ev_c | rep_ev_c;

    // Bad wins a same-cycle collision; the good event waits one cycle in pend
    always_comb begin
        bad_pulse_d  = ev_c[CH_BAD];
        good_pulse_d = 1'b0;
        pend_d       = 1'b0;
        if (ev_c[CH_BAD]) begin
            pend_d = ev_c[CH_GOOD] | pend_q;
        end else begin
            good_pulse_d = ev_c[CH_GOOD] | pend_q;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_pulse_q <= 1'b0;
            bad_pulse_q  <= 1'b0;
            pend_q       <= 1'b0;
            held_q       <= '0;
        end else begin
            good_pulse_q <= good_pulse_d;
            bad_pulse_q  <= bad_pulse_d;
            pend_q       <= pend_d;
            held_q       <= held_d;
        end
    end

    assign goodCollButton = good_pulse_q;
    assign badCollButton  = bad_pulse_q;
    assign goodHeld       = held_q[CH_GOOD];
    assign badHeld        = held_q[CH_BAD];

endmodule

// File: tb/tb_coll_button_conditioner.sv
// Testbench for coll_button_conditioner: directed button scenarios plus random
// bouncing, checked through a scoreboard fed by a debounced-level reference model.
`timescale 1ns/1ps

module tb_coll_button_conditioner;

    localparam int D = 3;
    localparam int R = 20;
`ifdef COLL_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic good_raw;
    logic bad_raw;
    logic good_btn;
    logic bad_btn;
    logic good_held;
    logic bad_held;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_good = 0;
    int n_bad  = 0;
    int good_q[$];
    int bad_q[$];

    // Reference model state: raw sample history, debounced level, run of differing samples
    bit h1[2];
    bit h2[2];
    bit lvl[2];
    int run[2];
`ifdef COLL_AUTOREPEAT_EN
    int hr[2];
`endif
    bit pend;
    bit exp_held[2];

    coll_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .goodCollRaw   (good_raw),
        .badCollRaw    (bad_raw),
        .goodCollButton(good_btn),
        .badCollButton (bad_btn),
        .goodHeld      (good_held),
        .badHeld       (bad_held)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Model: a level flips after D consecutive synced samples that differ from it.
    // The FSM decides at edge k on the raw value sampled at edge k-2.
    always @(posedge clk or negedge rst) begin
        bit ev[2];
        bit raw_s[2];
        bit s;
        if (!rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                h1[ch] = 1'b0;
                h2[ch] = 1'b0;
                lvl[ch] = 1'b0;
                run[ch] = 0;
`ifdef COLL_AUTOREPEAT_EN
                hr[ch] = 0;
`endif
                exp_held[ch] = 1'b0;
            end
            pend = 1'b0;
            good_q.delete();
            bad_q.delete();
        end else begin
            cyc++;
            raw_s[0] = good_raw;
            raw_s[1] = bad_raw;
            for (int ch = 0; ch < 2; ch++) begin
                ev[ch] = 1'b0;
                s = h2[ch];
                h2[ch] = h1[ch];
                h1[ch] = raw_s[ch];
`ifdef COLL_AUTOREPEAT_EN
                if (lvl[ch] && run[ch] == 0) begin
                    hr[ch]++;
                    if (hr[ch] == R) begin
                        ev[ch] = 1'b1;
                        hr[ch] = 0;
                    end
                end else begin
                    hr[ch] = 0;
                end
`endif
                if (s != lvl[ch]) run[ch]++;
                else run[ch] = 0;
                if (run[ch] == D) begin
                    lvl[ch] = s;
                    run[ch] = 0;
                    if (s) ev[ch] = 1'b1;
                end
                exp_held[ch] = lvl[ch];
            end
            if (ev[1]) begin
                bad_q.push_back(cyc);
                if (ev[0]) pend = 1'b1;
            end else if (ev[0] || pend) begin
                good_q.push_back(cyc);
                pend = 1'b0;
            end
        end
    end

    // Monitor: pops an expected pulse when its cycle comes up, compares every cycle
    always @(negedge clk) begin
        if (rst) begin
            bit eg;
            bit eb;
            eg = 1'b0;
            eb = 1'b0;
            if (good_q.size() > 0 && good_q[0] == cyc) begin
                eg = 1'b1;
                void'(good_q.pop_front());
            end
            if (bad_q.size() > 0 && bad_q[0] == cyc) begin
                eb = 1'b1;
                void'(bad_q.pop_front());
            end
            chk("good_pulse", 32'(good_btn), 32'(eg));
            chk("bad_pulse", 32'(bad_btn), 32'(eb));
            chk("good_held", 32'(good_held), 32'(exp_held[0]));
            chk("bad_held", 32'(bad_held), 32'(exp_held[1]));
            if (good_btn === 1'b1) n_good++;
            if (bad_btn === 1'b1) n_bad++;
        end
    end

    // Drive raws 2ns after a posedge and keep them for n sampling edges
    task automatic hold(input logic g, input logic b, input int n);
        good_raw = g;
        bad_raw  = b;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int g0;
        int b0;
        int gl;
        int bl;
        logic g;
        logic b;

        rst      = 1'b0;
        good_raw = 1'b0;
        bad_raw  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_good_btn", 32'(good_btn), 0);
        chk("reset_bad_btn", 32'(bad_btn), 0);
        chk("reset_good_held", 32'(good_held), 0);
        chk("reset_bad_held", 32'(bad_held), 0);
        rst = 1'b1;
        hold(0, 0, 10);

        // Long good press
        g0 = n_good; b0 = n_bad;
        hold(1, 0, 30);
        hold(0, 0, 20);
        chk("long_press_good_count", n_good - g0, AR ? 2 : 1);
        chk("long_press_bad_count", n_bad - b0, 0);

        // Short glitches are rejected
        g0 = n_good;
        for (int k = 0; k < 5; k++) begin
            hold(1, 0, 2);
            hold(0, 0, 3);
        end
        hold(0, 0, 5);
        chk("glitch_good_count", n_good - g0, 0);

        // Release bounce yields a single pulse
        g0 = n_good;
        hold(1, 0, 10);
        for (int k = 0; k < 3; k++) begin
            hold(0, 0, 1);
            hold(1, 0, 1);
        end
        hold(1, 0, 10);
        hold(0, 0, 10);
        chk("bounce_good_count", n_good - g0, 1);

        // Simultaneous presses: bad first, good one cycle later
        g0 = n_good; b0 = n_bad;
        hold(1, 1, 10);
        hold(0, 0, 10);
        chk("simul_good_count", n_good - g0, 1);
        chk("simul_bad_count", n_bad - b0, 1);

        // 100 clean presses
        g0 = n_good; b0 = n_bad;
        for (int k = 0; k < 100; k++) begin
            hold(1, 0, 4);
            hold(0, 0, 10);
        end
        hold(0, 0, 5);
        chk("clean100_good_count", n_good - g0, 100);
        chk("clean100_bad_count", n_bad - b0, 0);

        // Random bouncing on both channels, occasional long holds
        gl = 0; bl = 0; g = 1'b0; b = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (gl == 0) begin
                g  = logic'($urandom_range(0, 1));
                gl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 45))
                                                 : int'($urandom_range(1, 7));
            end
            if (bl == 0) begin
                b  = logic'($urandom_range(0, 1));
                bl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 45))
                                                 : int'($urandom_range(1, 7));
            end
            hold(g, b, 1);
            gl--;
            bl--;
        end
        hold(0, 0, 15);

        // Reset mid-press with both raws high
        hold(1, 1, 8);
        rst = 1'b0;
        #1;
        chk("midreset_good_btn", 32'(good_btn), 0);
        chk("midreset_bad_btn", 32'(bad_btn), 0);
        chk("midreset_good_held", 32'(good_held), 0);
        chk("midreset_bad_held", 32'(bad_held), 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        g0 = n_good; b0 = n_bad;
        hold(1, 1, 12);
        chk("postreset_good_count", n_good - g0, 1);
        chk("postreset_bad_count", n_bad - b0, 1);
        hold(0, 0, 20);

        chk("drain_good_queue", good_q.size(), 0);
        chk("drain_bad_queue", bad_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
